// File: rtl/ctrl_pipe_tracker.sv
// ctrl_pipe_tracker: carries the decoded control bundle from ID through the
// EX, MEM and WB pipeline registers. It resolves the load-use stall, the
// branch/jump flush and the multi-cycle div freeze, and drives the PC/IF-ID
// hold and flush controls for the datapath.
module ctrl_pipe_tracker #(
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [10:0] id_ctrl,
    input  logic        id_is_div,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        flush_ifid,
    output logic        div_busy,
    output logic [10:0] ex_ctrl,
    output logic [10:0] mem_ctrl,
    output logic [10:0] wb_ctrl,
    output logic [4:0]  ex_dst,
    output logic [4:0]  mem_dst,
    output logic [4:0]  wb_dst,
    output logic        ex_valid,
    output logic        mem_valid,
    output logic        wb_valid
);

    // Bundle bit positions
    localparam int B_REGDST   = 0;
    localparam int B_REGWRITE = 3;
    localparam int B_MEMREAD  = 4;
    localparam int B_BRANCH   = 6;
    localparam int B_JUMP     = 7;

    // Counter reload: remaining frozen cycles after the div first enters EX
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    logic [10:0] ex_ctrl_q, ex_ctrl_d, mem_ctrl_q, mem_ctrl_d, wb_ctrl_q, wb_ctrl_d;
    logic [4:0]  ex_dst_q, ex_dst_d, mem_dst_q, mem_dst_d, wb_dst_q, wb_dst_d;
    logic        ex_valid_q, ex_valid_d, mem_valid_q, mem_valid_d, wb_valid_q, wb_valid_d;
    logic        ex_div_q, ex_div_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [10:0] cap_ctrl;
    logic [4:0]  cap_dst;
    logic        cap_div;
    logic        load_use;
    logic        take;
    logic        busy;

    // Capture masking: an empty ID slot becomes a clean bubble, never X
    always_comb begin
        cap_ctrl = 11'd0;
        cap_dst  = 5'd0;
        cap_div  = 1'b0;
        if (id_valid) begin
            cap_ctrl = id_ctrl;
            cap_div  = id_is_div;
            if (id_ctrl[B_REGWRITE])
                cap_dst = id_ctrl[B_REGDST] ? id_rd : id_rt;
        end
    end

    // Hazard detection on the instruction currently in EX; silenced during reset
    always_comb begin
        load_use = ~rst & ex_valid_q & ex_ctrl_q[B_MEMREAD] & (ex_dst_q != 5'd0) & id_valid
                   & ((ex_dst_q == id_rs) | (id_uses_rt & (ex_dst_q == id_rt)));
        take     = ~rst & ex_valid_q & ex_ctrl_q[B_BRANCH] & (ex_ctrl_q[B_JUMP] | ex_branch_taken);
        busy     = ~rst & ex_valid_q & ex_div_q & (cnt_q != 6'd0);
    end

    // Next-state with priority div freeze > taken branch > load-use > advance
    always_comb begin
        ex_ctrl_d   = cap_ctrl;
        ex_dst_d    = cap_dst;
        ex_valid_d  = id_valid;
        ex_div_d    = cap_div;
        cnt_d       = cap_div ? DIV_LOAD : 6'd0;
        mem_ctrl_d  = ex_ctrl_q;
        mem_dst_d   = ex_dst_q;
        mem_valid_d = ex_valid_q;
        wb_ctrl_d   = mem_ctrl_q;
        wb_dst_d    = mem_dst_q;
        wb_valid_d  = mem_valid_q;
        if (busy) begin
            ex_ctrl_d   = ex_ctrl_q;
            ex_dst_d    = ex_dst_q;
            ex_valid_d  = ex_valid_q;
            ex_div_d    = ex_div_q;
            cnt_d       = cnt_q - 6'd1;
            mem_ctrl_d  = 11'd0;
            mem_dst_d   = 5'd0;
            mem_valid_d = 1'b0;
        end else if (take || load_use) begin
            ex_ctrl_d   = 11'd0;
            ex_dst_d    = 5'd0;
            ex_valid_d  = 1'b0;
            ex_div_d    = 1'b0;
            cnt_d       = 6'd0;
        end
    end

    // Pipeline registers; reset clears every stage and aborts a pending div
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_q   <= 11'd0;
            ex_dst_q    <= 5'd0;
            ex_valid_q  <= 1'b0;
            ex_div_q    <= 1'b0;
            cnt_q       <= 6'd0;
            mem_ctrl_q  <= 11'd0;
            mem_dst_q   <= 5'd0;
            mem_valid_q <= 1'b0;
            wb_ctrl_q   <= 11'd0;
            wb_dst_q    <= 5'd0;
            wb_valid_q  <= 1'b0;
        end else begin
            ex_ctrl_q   <= ex_ctrl_d;
            ex_dst_q    <= ex_dst_d;
            ex_valid_q  <= ex_valid_d;
            ex_div_q    <= ex_div_d;
            cnt_q       <= cnt_d;
            mem_ctrl_q  <= mem_ctrl_d;
            mem_dst_q   <= mem_dst_d;
            mem_valid_q <= mem_valid_d;
            wb_ctrl_q   <= wb_ctrl_d;
            wb_dst_q    <= wb_dst_d;
            wb_valid_q  <= wb_valid_d;
        end
    end

    assign div_busy   = busy;
    assign flush_ifid = take & ~busy;
    assign stall      = busy | (load_use & ~take);
    assign ex_ctrl    = ex_ctrl_q;
    assign mem_ctrl   = mem_ctrl_q;
    assign wb_ctrl    = wb_ctrl_q;
    assign ex_dst     = ex_dst_q;
    assign mem_dst    = mem_dst_q;
    assign wb_dst     = wb_dst_q;
    assign ex_valid   = ex_valid_q;
    assign mem_valid  = mem_valid_q;
    assign wb_valid   = wb_valid_q;

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Scoreboard bench for ctrl_pipe_tracker: each stimulus cycle pushes the
// hand-computed outputs for that cycle; a monitor pops and compares on the
// falling edge.
module tb_ctrl_pipe_tracker;

    localparam int ADD = 11'h209;
    localparam int LW  = 11'h01E;
    localparam int ORI = 11'h30A;
    localparam int BEQ = 11'h140;
    localparam int JMP = 11'h0C0;
    localparam int LWB = 11'h05E;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [10:0] id_ctrl;
    logic        id_is_div;
    logic        id_uses_rt;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        ex_branch_taken;
    logic        stall, flush_ifid, div_busy;
    logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic        ex_valid, mem_valid, wb_valid;

    ctrl_pipe_tracker #(.DIV_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_is_div(id_is_div), .id_uses_rt(id_uses_rt), .id_rs(id_rs),
        .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_ifid(flush_ifid), .div_busy(div_busy),
        .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
        .ex_dst(ex_dst), .mem_dst(mem_dst), .wb_dst(wb_dst),
        .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stall; int flush; int busy;
        int exv; int exd; int exc;
        int memv; int memd; int wbv; int wbd;
        int step;
    } exp_t;

    exp_t exq[$];
    int checks   = 0;
    int failures = 0;
    int step_no  = 0;

    task automatic chk(input string name, input int stp, input int act, input int want_v);
        checks++;
        if (act !== want_v) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0d expected=%0d", name, stp, act, want_v);
        end
    endtask

    // Apply one cycle of ID-side inputs just after the rising edge
    task automatic drv(input int r, input int v, input int c, input int dv, input int urt,
                       input int rs, input int rt, input int rd, input int tk);
        @(posedge clk);
        #1;
        rst             = r[0];
        id_valid        = v[0];
        id_ctrl         = c[10:0];
        id_is_div       = dv[0];
        id_uses_rt      = urt[0];
        id_rs           = rs[4:0];
        id_rt           = rt[4:0];
        id_rd           = rd[4:0];
        ex_branch_taken = tk[0];
        step_no++;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Expected outputs during the cycle just driven
    task automatic want(input int s, input int f, input int b, input int exv, input int exd,
                        input int exc, input int memv, input int memd, input int wbv, input int wbd);
        exp_t e;
        e.stall = s; e.flush = f; e.busy = b;
        e.exv = exv; e.exd = exd; e.exc = exc;
        e.memv = memv; e.memd = memd; e.wbv = wbv; e.wbd = wbd;
        e.step = step_no;
        exq.push_back(e);
    endtask

    task automatic want0();
        want(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare against the scoreboard once per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("stall",      e.step, int'(stall),      e.stall);
                chk("flush_ifid", e.step, int'(flush_ifid), e.flush);
                chk("div_busy",   e.step, int'(div_busy),   e.busy);
                chk("ex_valid",   e.step, int'(ex_valid),   e.exv);
                chk("ex_dst",     e.step, int'(ex_dst),     e.exd);
                chk("ex_ctrl",    e.step, int'(ex_ctrl),    e.exc);
                chk("mem_valid",  e.step, int'(mem_valid),  e.memv);
                chk("mem_dst",    e.step, int'(mem_dst),    e.memd);
                chk("wb_valid",   e.step, int'(wb_valid),   e.wbv);
                chk("wb_dst",     e.step, int'(wb_dst),     e.wbd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; id_valid = 1'b0; id_ctrl = 11'd0; id_is_div = 1'b0; id_uses_rt = 1'b0;
        id_rs = 5'd0; id_rt = 5'd0; id_rd = 5'd0; ex_branch_taken = 1'b0;

        // Reset mid-stream of adds
        drv(1, 0, 0,   0, 0, 0, 0, 0, 0); want0();
        drv(0, 1, ADD, 0, 1, 1, 2, 3, 0); want0();
        drv(0, 1, ADD, 0, 1, 1, 2, 4, 0); want(0,0,0, 1,3,ADD, 0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 1, 2, 5, 0); want(0,0,0, 1,4,ADD, 1,3, 0,0);
        drv(1, 1, ADD, 0, 1, 1, 2, 6, 0); want(0,0,0, 1,5,ADD, 1,4, 1,3);
        drv(1, 1, ADD, 0, 1, 1, 2, 7, 0); want0();
        drv(0, 1, ADD, 0, 1, 1, 2, 8, 0); want0();
        idle();                           want(0,0,0, 1,8,ADD, 0,0, 0,0);
        drv(0, 0, LW,  0, 1, 1, 8, 9, 0); want(0,0,0, 0,0,0,   1,8, 0,0);
        idle();                           want(0,0,0, 0,0,0,   0,0, 1,8);
        idle();                           want0();

        // Load-use on rs, then lw $0 causes no stall
        drv(0, 1, LW,  0, 0, 1, 8, 0, 0);  want0();
        drv(0, 1, ADD, 0, 1, 8, 2, 10, 0); want(1,0,0, 1,8,LW,   0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 8, 2, 10, 0); want(0,0,0, 0,0,0,    1,8, 0,0);
        idle();                            want(0,0,0, 1,10,ADD, 0,0, 1,8);
        drv(0, 1, LW,  0, 0, 1, 0, 0, 0);  want(0,0,0, 0,0,0,    1,10, 0,0);
        drv(0, 1, ADD, 0, 1, 0, 2, 11, 0); want(0,0,0, 1,0,LW,   0,0, 1,10);
        idle();                            want(0,0,0, 1,11,ADD, 1,0, 0,0);
        idle();                            want(0,0,0, 0,0,0,    1,11, 1,0);

        // rt dependency only counts when rt is read
        drv(0, 1, LW,  0, 0, 1, 9, 0, 0);  want(0,0,0, 0,0,0,    0,0, 1,11);
        drv(0, 1, ORI, 0, 0, 1, 9, 0, 0);  want(0,0,0, 1,9,LW,   0,0, 0,0);
        drv(0, 1, LW,  0, 0, 1, 9, 0, 0);  want(0,0,0, 1,9,ORI,  1,9, 0,0);
        drv(0, 1, ADD, 0, 1, 1, 9, 12, 0); want(1,0,0, 1,9,LW,   1,9, 1,9);
        drv(0, 1, ADD, 0, 1, 1, 9, 12, 0); want(0,0,0, 0,0,0,    1,9, 1,9);
        idle();                            want(0,0,0, 1,12,ADD, 0,0, 1,9);
        idle();                            want(0,0,0, 0,0,0,    1,12, 0,0);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,12);
        idle();                            want0();

        // Back-to-back load-use: one bubble per dependency
        drv(0, 1, LW,  0, 0, 1, 8, 0, 0);  want0();
        drv(0, 1, LW,  0, 0, 8, 9, 0, 0);  want(1,0,0, 1,8,LW,   0,0, 0,0);
        drv(0, 1, LW,  0, 0, 8, 9, 0, 0);  want(0,0,0, 0,0,0,    1,8, 0,0);
        drv(0, 1, ADD, 0, 1, 9, 2, 13, 0); want(1,0,0, 1,9,LW,   0,0, 1,8);
        drv(0, 1, ADD, 0, 1, 9, 2, 13, 0); want(0,0,0, 0,0,0,    1,9, 0,0);
        idle();                            want(0,0,0, 1,13,ADD, 0,0, 1,9);
        idle();                            want(0,0,0, 0,0,0,    1,13, 0,0);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,13);
        idle();                            want0();

        // Branch taken, branch not taken, jump
        drv(0, 1, BEQ, 0, 1, 1, 2, 0, 0);  want0();
        drv(0, 1, ADD, 0, 1, 3, 4, 14, 1); want(0,1,0, 1,0,BEQ,  0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 3, 4, 15, 0); want(0,0,0, 0,0,0,    1,0, 0,0);
        drv(0, 1, BEQ, 0, 1, 1, 2, 0, 0);  want(0,0,0, 1,15,ADD, 0,0, 1,0);
        drv(0, 1, ADD, 0, 1, 3, 4, 16, 0); want(0,0,0, 1,0,BEQ,  1,15, 0,0);
        drv(0, 1, JMP, 0, 0, 0, 0, 0, 0);  want(0,0,0, 1,16,ADD, 1,0, 1,15);
        drv(0, 1, ADD, 0, 1, 3, 4, 17, 0); want(0,1,0, 1,0,JMP,  1,16, 1,0);
        idle();                            want(0,0,0, 0,0,0,    1,0, 1,16);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,0);
        idle();                            want0();

        // lw in MEM, taken beq in EX, dependent add in ID
        drv(0, 1, LW,  0, 0, 1, 8, 0, 0);  want0();
        drv(0, 1, BEQ, 0, 1, 1, 2, 0, 0);  want(0,0,0, 1,8,LW,   0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 8, 2, 18, 1); want(0,1,0, 1,0,BEQ,  1,8, 0,0);
        idle();                            want(0,0,0, 0,0,0,    1,0, 1,8);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,0);
        idle();                            want0();

        // load_use and take both raised: flush wins, no stall
        drv(0, 1, LWB, 0, 0, 1, 8, 0, 0);  want0();
        drv(0, 1, ADD, 0, 1, 8, 2, 19, 1); want(0,1,0, 1,8,LWB,  0,0, 0,0);
        idle();                            want(0,0,0, 0,0,0,    1,8, 0,0);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,8);
        idle();                            want0();

        // Div freeze with DIV_CYCLES=4
        drv(0, 1, ADD, 1, 1, 1, 2, 20, 0); want0();
        drv(0, 1, ADD, 0, 1, 1, 2, 21, 0); want(1,0,1, 1,20,ADD, 0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 1, 2, 21, 0); want(1,0,1, 1,20,ADD, 0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 1, 2, 21, 0); want(1,0,1, 1,20,ADD, 0,0, 0,0);
        drv(0, 1, ADD, 0, 1, 1, 2, 21, 0); want(0,0,0, 1,20,ADD, 0,0, 0,0);
        idle();                            want(0,0,0, 1,21,ADD, 1,20, 0,0);
        idle();                            want(0,0,0, 0,0,0,    1,21, 1,20);
        idle();                            want(0,0,0, 0,0,0,    0,0, 1,21);
        idle();                            want0();

        // Reset while the div counter is at 2 discards the div
        drv(0, 1, ADD, 1, 1, 1, 2, 22, 0); want0();
        drv(0, 1, ADD, 0, 1, 1, 2, 23, 0); want(1,0,1, 1,22,ADD, 0,0, 0,0);
        drv(1, 1, ADD, 0, 1, 1, 2, 23, 0); want(0,0,0, 1,22,ADD, 0,0, 0,0);
        idle();                            want0();
        idle();                            want0();

        for (int i = 0; i < 10 && exq.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain remaining=%0d expected=0", exq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
